// File: rtl/ent_pkg.sv
// Shared types and constants for the entity table scan: slot codes, scan states and box records.
// Also provides the inclusive box containment test used by the pixel lookup.
package ent_pkg;

  localparam int N_SLOTS_DEF = 4;
  localparam int SLOT_MAX    = 4;

  // Entity code per slot: food, enemy, then two spare codes
  localparam logic [9:0] SLOT_CODE [SLOT_MAX] = '{10'd0, 10'd2, 10'd4, 10'd6};

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPT,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [7:0] tlx;
    logic [7:0] tly;
    logic [7:0] brx;
    logic [7:0] bry;
  } box_t;

  function automatic logic box_hit(input box_t b, input logic [9:0] x, input logic [9:0] y);
    return ({2'b00, b.tlx} <= x) && (x <= {2'b00, b.brx}) &&
           ({2'b00, b.tly} <= y) && (y <= {2'b00, b.bry});
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the vsync-rate frame tick into the system clock domain and emits a one-cycle pulse
// on each rising edge; shared by any block that works at frame rate.
module frame_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic fedge
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fedge = sync2 & ~prev;

endmodule

// File: rtl/entity_scan_controller.sv
// Walks the entity table once per frame, keeps a local copy of every bounding box for the
// colour mapper's per-pixel lookup, and turns eaten/hurt flags into score, lives and game over.
module entity_scan_controller
  import ent_pkg::*;
#(
  parameter int N_SLOTS    = N_SLOTS_DEF,
  parameter int SETTLE     = 2,
  parameter int LIVES_INIT = 3,
  parameter int INVULN_FRM = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       eaten,
  input  logic       hurt,
  input  logic [7:0] TLX,
  input  logic [7:0] TLY,
  input  logic [7:0] BRX,
  input  logic [7:0] BRY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] Entity,
  output logic       pix_hit,
  output logic [1:0] pix_slot,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       scan_busy,
  output logic       overrun
);

  scan_state_t         state;
  logic [1:0]          slot;
  logic [3:0]          cnt;
  box_t                box [SLOT_MAX];
  logic [SLOT_MAX-1:0] slot_valid;
  logic [5:0]          invuln;
  logic                fedge;
  logic                hit_any;
  logic [1:0]          hit_idx;

  frame_edge_sync u_sync (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .fedge     (fedge)
  );

  // scan_busy stays up for one IDLE cycle after DONE so a late frame edge there counts as overrun
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      slot       <= '0;
      cnt        <= '0;
      Entity     <= SLOT_CODE[0];
      scan_busy  <= 1'b0;
      overrun    <= 1'b0;
      slot_valid <= '0;
      for (int k = 0; k < SLOT_MAX; k++) box[k] <= '0;
    end else begin
      if (fedge && scan_busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (fedge && !scan_busy) begin
            state     <= DRIVE;
            slot      <= '0;
            cnt       <= 4'(SETTLE - 1);
            Entity    <= SLOT_CODE[0];
            scan_busy <= 1'b1;
          end else begin
            scan_busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) state <= CAPT;
          else             cnt   <= cnt - 4'd1;
        end
        CAPT: begin
          box[slot]        <= '{tlx: TLX, tly: TLY, brx: BRX, bry: BRY};
          slot_valid[slot] <= 1'b1;
          if (slot == 2'(N_SLOTS - 1)) begin
            state  <= DONE;
            Entity <= SLOT_CODE[0];
          end else begin
            state  <= DRIVE;
            slot   <= slot + 2'd1;
            cnt    <= 4'(SETTLE - 1);
            Entity <= SLOT_CODE[slot + 2'd1];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      score     <= '0;
      lives     <= 2'(LIVES_INIT);
      game_over <= 1'b0;
      invuln    <= '0;
    end else if (fedge && !game_over) begin
      if (eaten && score != 8'hFF) score <= score + 8'd1;
      if (hurt && invuln == 6'd0 && lives != 2'd0) begin
        lives  <= lives - 2'd1;
        invuln <= 6'(INVULN_FRM);
        if (lives == 2'd1) game_over <= 1'b1;
      end else if (invuln != 6'd0) begin
        invuln <= invuln - 6'd1;
      end
    end
  end

  // Descending walk so the lowest-numbered hit wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = SLOT_MAX - 1; k >= 0; k--) begin
      if (slot_valid[k] && box_hit(box[k], DrawX, DrawY)) begin
        hit_any = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_hit  <= 1'b0;
      pix_slot <= '0;
    end else begin
      pix_hit  <= hit_any;
      pix_slot <= hit_idx;
    end
  end

endmodule

// File: tb/tb_entity_scan_controller.sv
// Directed bench for entity_scan_controller: scan walk, pixel lookup, score/lives events,
// overrun handling and mid-scan reset, with hand-computed expectations.
module tb_entity_scan_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       eaten;
  logic       hurt;
  logic [7:0] TLX, TLY, BRX, BRY;
  logic [9:0] DrawX, DrawY;
  logic [9:0] Entity;
  logic       pix_hit;
  logic [1:0] pix_slot;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       scan_busy;
  logic       overrun;

  int         n_total = 0;
  int         n_bad   = 0;
  int         busy_n;
  int         tbl_mode = 0;
  logic [9:0] ent_log [16];

  entity_scan_controller #(
    .N_SLOTS    (4),
    .SETTLE     (2),
    .LIVES_INIT (3),
    .INVULN_FRM (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .eaten     (eaten),
    .hurt      (hurt),
    .TLX       (TLX),
    .TLY       (TLY),
    .BRX       (BRX),
    .BRY       (BRY),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .Entity    (Entity),
    .pix_hit   (pix_hit),
    .pix_slot  (pix_slot),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .scan_busy (scan_busy),
    .overrun   (overrun)
  );

  always #10 Clk = ~Clk;

  // Entity table model: mode 0 returns one box for every code, mode 1 a distinct box per code
  always_comb begin
    TLX = 8'd10; TLY = 8'd20; BRX = 8'd30; BRY = 8'd40;
    if (tbl_mode == 1) begin
      case (Entity)
        10'd0:   begin TLX = 8'd10;  TLY = 8'd10;  BRX = 8'd20;  BRY = 8'd20;  end
        10'd2:   begin TLX = 8'd15;  TLY = 8'd15;  BRX = 8'd25;  BRY = 8'd25;  end
        10'd4:   begin TLX = 8'd100; TLY = 8'd100; BRX = 8'd110; BRY = 8'd110; end
        default: begin TLX = 8'd200; TLY = 8'd200; BRX = 8'd190; BRY = 8'd190; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One 40-cycle frame; logs Entity on every cycle scan_busy is high
  task automatic frame(input logic e, input logic h);
    eaten  = e;
    hurt   = h;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (i == 0)  frame_clk = 1'b1;
      if (i == 24) frame_clk = 1'b0;
      if (scan_busy) begin
        if (busy_n < 16) ent_log[busy_n] = Entity;
        busy_n++;
      end
    end
    eaten = 1'b0;
    hurt  = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic eh, input logic [1:0] es);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    @(negedge Clk);
    chk({tag, "_hit"}, pix_hit, eh);
    if (eh) chk({tag, "_slot"}, pix_slot, es);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    frame_clk = 1'b0;
    Reset     = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    logic found;
    int   n;
    Reset = 1'b1; frame_clk = 1'b0; eaten = 1'b0; hurt = 1'b0;
    DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    chk("rst_entity", Entity, 0);
    chk("rst_busy", scan_busy, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_gameover", game_over, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pixhit", pix_hit, 0);
    chk("rst_pixslot", pix_slot, 0);
    Reset = 1'b0;
    pix("rst_nohit", 0, 0, 1'b0, 2'd0);

    // Scan walk with a uniform table
    frame(1'b0, 1'b0);
    chk("t1_busy_len", busy_n, 14);
    chk("t1_ent0", ent_log[0], 0);
    chk("t1_ent_capt0", ent_log[2], 0);
    chk("t1_ent1", ent_log[3], 2);
    chk("t1_ent1b", ent_log[4], 2);
    chk("t1_ent2", ent_log[6], 4);
    chk("t1_ent3", ent_log[9], 6);
    chk("t1_ent3_capt", ent_log[11], 6);
    chk("t1_ent_done", ent_log[12], 0);
    pix("t1_corner", 30, 40, 1'b1, 2'd0);
    pix("t1_outside", 31, 40, 1'b0, 2'd0);

    // Distinct boxes per slot
    tbl_mode = 1;
    frame(1'b0, 1'b0);
    chk("t2_busy_len", busy_n, 14);
    pix("t2_p18", 18, 18, 1'b1, 2'd0);
    pix("t2_p24", 24, 24, 1'b1, 2'd1);
    pix("t2_p26", 26, 26, 1'b0, 2'd0);
    pix("t2_slot2", 100, 110, 1'b1, 2'd2);
    pix("t2_wrap", 195, 195, 1'b0, 2'd0);
    pix("t2_xhigh", 266, 15, 1'b0, 2'd0);

    // Second frame edge during a scan
    chk("t5_pre_overrun", overrun, 0);
    @(negedge Clk);
    frame_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (scan_busy) found = 1'b1;
    end
    chk("t5_start", found, 1);
    n = found ? 1 : 0;
    for (int j = 1; j < 60; j++) begin
      @(negedge Clk);
      if (j == 2) frame_clk = 1'b0;
      if (j == 4) frame_clk = 1'b1;
      if (scan_busy) n++;
    end
    chk("t5_busy_len", n, 14);
    chk("t5_overrun", overrun, 1);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    frame(1'b0, 1'b0);
    chk("t5_next_len", busy_n, 14);
    chk("t5_overrun_sticky", overrun, 1);

    // Reset while driving slot 1
    DrawX = 10'd18; DrawY = 10'd18;
    @(negedge Clk);
    frame_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (scan_busy && Entity == 10'd2) found = 1'b1;
    end
    chk("t6_reach_slot1", found, 1);
    chk("t6_pre_hit", pix_hit, 1);
    #3;
    Reset = 1'b1;
    frame_clk = 1'b0;
    #1;
    chk("t6_entity", Entity, 0);
    chk("t6_busy", scan_busy, 0);
    chk("t6_pixhit", pix_hit, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_lives", lives, 3);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("t6_cleared_boxes", pix_hit, 0);
    frame(1'b0, 1'b0);
    chk("t6_busy_len", busy_n, 14);
    chk("t6_ent0", ent_log[0], 0);
    chk("t6_ent1", ent_log[3], 2);
    chk("t6_rehit", pix_hit, 1);

    // Score saturation
    for (int f = 1; f <= 257; f++) begin
      frame(1'b1, 1'b0);
      if (f == 1)   chk("t3_score1", score, 1);
      if (f == 254) chk("t3_score254", score, 254);
      if (f == 255) chk("t3_score255", score, 255);
    end
    chk("t3_score_sat", score, 255);

    // Lives, invulnerability and game over
    do_reset();
    for (int f = 1; f <= 7; f++) begin
      frame(1'b1, 1'b1);
      if (f == 1) chk("t4_lives_f1", lives, 2);
      if (f == 3) chk("t4_lives_f3", lives, 2);
      if (f == 4) chk("t4_lives_f4", lives, 1);
      if (f == 6) chk("t4_lives_f6", lives, 1);
      if (f == 6) chk("t4_go_f6", game_over, 0);
    end
    chk("t4_lives_f7", lives, 0);
    chk("t4_go_f7", game_over, 1);
    chk("t4_score_f7", score, 7);
    for (int f = 0; f < 3; f++) frame(1'b1, 1'b1);
    chk("t4_score_frozen", score, 7);
    chk("t4_lives_frozen", lives, 0);
    chk("t4_scan_runs", busy_n, 14);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
